// File: rtl/connect4_turn_controller_pkg.sv
// Shared constants, state encoding and board helpers for the connect-four
// game master.
//   - Board geometry: 7 columns x 6 rows, cell (c,r) at bit c*6+r.
//   - Column heights: 3 bits per column, column c at bits [3c+2:3c].
//   - Helpers: column height lookup, stone drop (piler), 4-in-a-row checker.
package connect4_turn_controller_pkg;

    localparam int ROWS                   = 6;
    localparam int COLS                   = 7;
    localparam int FIELD_SIZE             = 42;
    localparam int COL_SIZE               = 3;
    localparam int HEIGHT_W               = 3;
    localparam int PILED_COUNT_ARRAY_SIZE = 21;

    localparam logic [HEIGHT_W-1:0] FULL_HEIGHT = 3'd6;
    localparam logic [COL_SIZE-1:0] MAX_COL     = 3'd6;
    localparam logic [5:0]          MAX_MOVES   = 6'd42;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_HUMAN = 2'b01;
    localparam logic [1:0] WIN_AI    = 2'b10;
    localparam logic [1:0] WIN_DRAW  = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_P,
        ST_APPLY_P,
        ST_CHECK_P,
        ST_LAUNCH,
        ST_SEARCH,
        ST_APPLY_AI,
        ST_CHECK_AI,
        ST_OVER
    } state_e;

    typedef struct packed {
        logic [FIELD_SIZE-1:0]             field;
        logic [PILED_COUNT_ARRAY_SIZE-1:0] piled;
    } pile_t;

    // Height of one column; out-of-range columns read as empty.
    function automatic logic [HEIGHT_W-1:0] col_height(
        input logic [PILED_COUNT_ARRAY_SIZE-1:0] piled,
        input logic [COL_SIZE-1:0]               col
    );
        logic [HEIGHT_W-1:0] h;
        h = '0;
        if (col <= MAX_COL) begin
            h = piled[int'(col)*HEIGHT_W +: HEIGHT_W];
        end
        return h;
    endfunction

    // Drop one stone into a column: set the cell on top of the pile and
    // bump that column's height. Illegal drops leave the board untouched.
    function automatic pile_t pile(
        input logic [FIELD_SIZE-1:0]             field,
        input logic [PILED_COUNT_ARRAY_SIZE-1:0] piled,
        input logic [COL_SIZE-1:0]               col
    );
        pile_t               res;
        logic [HEIGHT_W-1:0] h;
        h         = col_height(piled, col);
        res.field = field;
        res.piled = piled;
        if ((col <= MAX_COL) && (h != FULL_HEIGHT)) begin
            res.field[int'(col)*ROWS + int'(h)]          = 1'b1;
            res.piled[int'(col)*HEIGHT_W +: HEIGHT_W]    = h + 3'd1;
        end
        return res;
    endfunction

    // True when the field holds four stones in a line in any direction.
    function automatic logic has_four(input logic [FIELD_SIZE-1:0] f);
        logic hit;
        hit = 1'b0;
        // vertical
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS-3; r++) begin
                if (f[c*ROWS+r] && f[c*ROWS+r+1] && f[c*ROWS+r+2] && f[c*ROWS+r+3]) hit = 1'b1;
            end
        end
        // horizontal
        for (int c = 0; c < COLS-3; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (f[c*ROWS+r] && f[(c+1)*ROWS+r] && f[(c+2)*ROWS+r] && f[(c+3)*ROWS+r]) hit = 1'b1;
            end
        end
        // rising diagonal
        for (int c = 0; c < COLS-3; c++) begin
            for (int r = 0; r < ROWS-3; r++) begin
                if (f[c*ROWS+r] && f[(c+1)*ROWS+r+1] && f[(c+2)*ROWS+r+2] && f[(c+3)*ROWS+r+3]) hit = 1'b1;
            end
        end
        // falling diagonal
        for (int c = 0; c < COLS-3; c++) begin
            for (int r = 3; r < ROWS; r++) begin
                if (f[c*ROWS+r] && f[(c+1)*ROWS+r-1] && f[(c+2)*ROWS+r-2] && f[(c+3)*ROWS+r-3]) hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/connect4_turn_controller_if.sv
// Search-tree handshake between the game master (master) and the minimax
// tree (slave).
//   search_en       master->slave  one-cycle launch pulse
//   search_rst      master->slave  one-cycle tree reset pulse (active-high)
//   search_valid    slave->master  tree result valid
//   search_finished slave->master  tree search finished
//   search_col      slave->master  selected column
interface connect4_turn_controller_if;
    import connect4_turn_controller_pkg::*;

    logic                search_en;
    logic                search_rst;
    logic                search_valid;
    logic                search_finished;
    logic [COL_SIZE-1:0] search_col;

    modport master (
        output search_en,
        output search_rst,
        input  search_valid,
        input  search_finished,
        input  search_col
    );

    modport slave (
        input  search_en,
        input  search_rst,
        output search_valid,
        output search_finished,
        output search_col
    );
endinterface

// File: rtl/connect4_turn_controller_fallback_col.sv
// Priority encoder: lowest-index column whose height is below 6.
//   i_piled_array  per-column heights (3 bits each)
//   o_col          first non-full column (0 when every column is full)
module connect4_turn_controller_fallback_col
    import connect4_turn_controller_pkg::*;
(
    input  logic [PILED_COUNT_ARRAY_SIZE-1:0] i_piled_array,
    output logic [COL_SIZE-1:0]               o_col
);

    // Scan downwards so the lowest non-full index is the last one written.
    always_comb begin
        o_col = '0;
        for (int c = COLS-1; c >= 0; c--) begin
            if (i_piled_array[c*HEIGHT_W +: HEIGHT_W] != FULL_HEIGHT) begin
                o_col = COL_SIZE'(c);
            end
        end
    end

endmodule

// File: rtl/connect4_turn_controller.sv
// Connect-four game master: owns the board (me = AI, op = human), accepts
// human moves, launches the minimax tree and applies its column.
//   w_clk, w_rst_n       clock, asynchronous active-low reset
//   i_start              pulse: clear board and start a new game
//   i_player_valid/col   human move request
//   search               tree handshake (master side)
//   o_me/op_field        AI / human stones, o_piled_array column heights
//   o_player_turn        waiting for a human move
//   o_move_reject        pulse: illegal human move
//   o_ai_col(_valid)     last AI column / pulse when applied
//   o_game_over, o_winner  00 none, 01 human, 10 AI, 11 draw
module connect4_turn_controller
    import connect4_turn_controller_pkg::*;
#(
    parameter bit          AI_FIRST       = 1'b0,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'hFFFFFF
) (
    input  logic                              w_clk,
    input  logic                              w_rst_n,
    input  logic                              i_start,
    input  logic                              i_player_valid,
    input  logic [COL_SIZE-1:0]               i_player_col,
    connect4_turn_controller_if.master        search,
    output logic [FIELD_SIZE-1:0]             o_me_field,
    output logic [FIELD_SIZE-1:0]             o_op_field,
    output logic [PILED_COUNT_ARRAY_SIZE-1:0] o_piled_array,
    output logic                              o_player_turn,
    output logic                              o_move_reject,
    output logic [COL_SIZE-1:0]               o_ai_col,
    output logic                              o_ai_col_valid,
    output logic                              o_game_over,
    output logic [1:0]                        o_winner
);

    state_e                            state_q, state_d;
    logic [FIELD_SIZE-1:0]             me_q, me_d, op_q, op_d;
    logic [PILED_COUNT_ARRAY_SIZE-1:0] piled_q, piled_d;
    logic [5:0]                        move_cnt_q, move_cnt_d;
    logic [23:0]                       tmo_cnt_q, tmo_cnt_d;
    logic [COL_SIZE-1:0]               col_q, col_d;
    logic                              fallback_q, fallback_d;
    logic [1:0]                        winner_q, winner_d;
    logic                              search_en_q, search_en_d;
    logic                              search_rst_q, search_rst_d;
    logic                              reject_q, reject_d;
    logic [COL_SIZE-1:0]               ai_col_q, ai_col_d;
    logic                              ai_col_valid_q, ai_col_valid_d;
    logic                              player_turn_q, player_turn_d;
    logic                              game_over_q, game_over_d;

    logic [COL_SIZE-1:0]   fb_col;
    logic [COL_SIZE-1:0]   ai_sel;
    logic [FIELD_SIZE-1:0] pile_field;
    logic [COL_SIZE-1:0]   pile_col;
    pile_t                 pile_res;
    logic [FIELD_SIZE-1:0] chk_field;
    logic                  four_hit;
    logic                  player_col_ok;

    connect4_turn_controller_fallback_col u_fallback (
        .i_piled_array (piled_q),
        .o_col         (fb_col)
    );

    // Shared piler and checker: the state decides whose field they see.
    always_comb begin
        if ((col_q > MAX_COL) || (col_height(piled_q, col_q) == FULL_HEIGHT) || fallback_q) begin
            ai_sel = fb_col;
        end else begin
            ai_sel = col_q;
        end
        pile_field = op_q;
        pile_col   = col_q;
        if (state_q == ST_APPLY_AI) begin
            pile_field = me_q;
            pile_col   = ai_sel;
        end
        pile_res      = pile(pile_field, piled_q, pile_col);
        chk_field     = (state_q == ST_CHECK_AI) ? me_q : op_q;
        four_hit      = has_four(chk_field);
        player_col_ok = (i_player_col <= MAX_COL) &&
                        (col_height(piled_q, i_player_col) != FULL_HEIGHT);
    end

    always_comb begin
        state_d        = state_q;
        me_d           = me_q;
        op_d           = op_q;
        piled_d        = piled_q;
        move_cnt_d     = move_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        col_d          = col_q;
        fallback_d     = fallback_q;
        winner_d       = winner_q;
        ai_col_d       = ai_col_q;
        search_en_d    = 1'b0;
        search_rst_d   = 1'b0;
        reject_d       = 1'b0;
        ai_col_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_WAIT_P: begin
                if (i_player_valid) begin
                    if (player_col_ok) begin
                        col_d   = i_player_col;
                        state_d = ST_APPLY_P;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            ST_APPLY_P: begin
                op_d       = pile_res.field;
                piled_d    = pile_res.piled;
                move_cnt_d = move_cnt_q + 6'd1;
                state_d    = ST_CHECK_P;
            end
            ST_CHECK_P, ST_CHECK_AI: begin
                if (four_hit) begin
                    winner_d = (state_q == ST_CHECK_AI) ? WIN_AI : WIN_HUMAN;
                    state_d  = ST_OVER;
                end else if (move_cnt_q == MAX_MOVES) begin
                    winner_d = WIN_DRAW;
                    state_d  = ST_OVER;
                end else if (state_q == ST_CHECK_AI) begin
                    state_d = ST_WAIT_P;
                end else begin
                    // launch pulse is registered so it is high during LAUNCH
                    search_en_d = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tmo_cnt_d = '0;
                state_d   = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (search.search_valid && search.search_finished) begin
                    col_d      = search.search_col;
                    fallback_d = 1'b0;
                    state_d    = ST_APPLY_AI;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 24'd1;
                    if ((TIMEOUT_CYCLES != 24'd0) && (tmo_cnt_d == TIMEOUT_CYCLES)) begin
                        search_rst_d = 1'b1;
                        fallback_d   = 1'b1;
                        state_d      = ST_APPLY_AI;
                    end
                end
            end
            ST_APPLY_AI: begin
                me_d           = pile_res.field;
                piled_d        = pile_res.piled;
                ai_col_d       = ai_sel;
                ai_col_valid_d = 1'b1;
                move_cnt_d     = move_cnt_q + 6'd1;
                fallback_d     = 1'b0;
                state_d        = ST_CHECK_AI;
            end
            ST_OVER: ;
            default: state_d = ST_IDLE;
        endcase

        // A new game overrides whatever the current state decided.
        if (i_start) begin
            me_d           = '0;
            op_d           = '0;
            piled_d        = '0;
            move_cnt_d     = '0;
            tmo_cnt_d      = '0;
            fallback_d     = 1'b0;
            winner_d       = WIN_NONE;
            reject_d       = 1'b0;
            ai_col_valid_d = 1'b0;
            search_rst_d   = 1'b1;
            search_en_d    = AI_FIRST;
            state_d        = AI_FIRST ? ST_LAUNCH : ST_WAIT_P;
        end

        player_turn_d = (state_d == ST_WAIT_P);
        game_over_d   = (state_d == ST_OVER);
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q        <= ST_IDLE;
            me_q           <= '0;
            op_q           <= '0;
            piled_q        <= '0;
            move_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            col_q          <= '0;
            fallback_q     <= 1'b0;
            winner_q       <= WIN_NONE;
            search_en_q    <= 1'b0;
            search_rst_q   <= 1'b0;
            reject_q       <= 1'b0;
            ai_col_q       <= '0;
            ai_col_valid_q <= 1'b0;
            player_turn_q  <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            me_q           <= me_d;
            op_q           <= op_d;
            piled_q        <= piled_d;
            move_cnt_q     <= move_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            col_q          <= col_d;
            fallback_q     <= fallback_d;
            winner_q       <= winner_d;
            search_en_q    <= search_en_d;
            search_rst_q   <= search_rst_d;
            reject_q       <= reject_d;
            ai_col_q       <= ai_col_d;
            ai_col_valid_q <= ai_col_valid_d;
            player_turn_q  <= player_turn_d;
            game_over_q    <= game_over_d;
        end
    end

    assign search.search_en  = search_en_q;
    assign search.search_rst = search_rst_q;
    assign o_me_field        = me_q;
    assign o_op_field        = op_q;
    assign o_piled_array     = piled_q;
    assign o_player_turn     = player_turn_q;
    assign o_move_reject     = reject_q;
    assign o_ai_col          = ai_col_q;
    assign o_ai_col_valid    = ai_col_valid_q;
    assign o_game_over       = game_over_q;
    assign o_winner          = winner_q;

endmodule
